// File: rtl/sram_like_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like memory port between the instruction and data caches.
// One outstanding transaction; ties go to the data side or alternate, selected by DATA_PRIORITY.
module sram_like_arbiter #(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req_i,
    input  logic        inst_wr_i,
    input  logic [1:0]  inst_size_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] inst_wdata_i,
    output logic [31:0] inst_rdata_o,
    output logic        inst_addr_ok_o,
    output logic        inst_data_ok_o,

    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_size_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_addr_ok_o,
    output logic        data_data_ok_o,

    output logic        bus_req_o,
    output logic        bus_wr_o,
    output logic [1:0]  bus_size_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_addr_ok_i,
    input  logic        bus_data_ok_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        lastGrant_q, lastGrant_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        grantData;
    logic        addrOkPulse;
    logic        dataOkPulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            wr_q        <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        wr_d        = wr_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        grantData   = 1'b0;
        addrOkPulse = 1'b0;
        dataOkPulse = 1'b0;
        bus_req_o   = 1'b0;

        case (state_q)
            IDLE: begin
                // Stale bus handshakes seen here are deliberately dropped.
                if (inst_req_i || data_req_i) begin
                    if (inst_req_i && data_req_i) begin
                        grantData = DATA_PRIORITY ? 1'b1 : !lastGrant_q;
                    end else begin
                        grantData = data_req_i;
                    end
                    owner_d     = grantData;
                    lastGrant_d = grantData;
                    wr_d        = grantData ? data_wr_i    : inst_wr_i;
                    size_d      = grantData ? data_size_i  : inst_size_i;
                    addr_d      = grantData ? data_addr_i  : inst_addr_i;
                    wdata_d     = grantData ? data_wdata_i : inst_wdata_i;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                bus_req_o = 1'b1;
                if (bus_addr_ok_i) begin
                    addrOkPulse = 1'b1;
                    if (bus_data_ok_i) begin
                        dataOkPulse = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (bus_data_ok_i) begin
                    dataOkPulse = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus_wr_o       = wr_q;
    assign bus_size_o     = size_q;
    assign bus_addr_o     = addr_q;
    assign bus_wdata_o    = wdata_q;

    assign inst_rdata_o   = bus_rdata_i;
    assign data_rdata_o   = bus_rdata_i;
    assign inst_addr_ok_o = addrOkPulse & ~owner_q;
    assign inst_data_ok_o = dataOkPulse & ~owner_q;
    assign data_addr_ok_o = addrOkPulse &  owner_q;
    assign data_data_ok_o = dataOkPulse &  owner_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: a fixed-priority instance (dut1) and a round-robin
// instance (dut0) share the master and bus stimulus; expected bus transactions are queued when issued.
module tb_sram_like_arbiter;

    typedef struct packed {
        logic        owner;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        instReq = 1'b0, instWr = 1'b0;
    logic [1:0]  instSize = 2'd0;
    logic [31:0] instAddr = 32'd0, instWdata = 32'd0;
    logic        dataReq = 1'b0, dataWr = 1'b0;
    logic [1:0]  dataSize = 2'd0;
    logic [31:0] dataAddr = 32'd0, dataWdata = 32'd0;
    logic [31:0] busRdata = 32'd0;
    logic        busAddrOk = 1'b0, busDataOk = 1'b0;

    logic [31:0] instRdata1, dataRdata1, busAddr1, busWdata1;
    logic        instAddrOk1, instDataOk1, dataAddrOk1, dataDataOk1, busReq1, busWr1;
    logic [1:0]  busSize1;
    logic [31:0] instRdata0, dataRdata0, busAddr0, busWdata0;
    logic        instAddrOk0, instDataOk0, dataAddrOk0, dataDataOk0, busReq0, busWr0;
    logic [1:0]  busSize0;

    logic [3:0]  oks1, oks0;
    logic [66:0] bus1, bus0;
    assign oks1 = {instAddrOk1, instDataOk1, dataAddrOk1, dataDataOk1};
    assign oks0 = {instAddrOk0, instDataOk0, dataAddrOk0, dataDataOk0};
    assign bus1 = {busWr1, busSize1, busAddr1, busWdata1};
    assign bus0 = {busWr0, busSize0, busAddr0, busWdata0};

    txn_t expQ[$];
    txn_t exp;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.DATA_PRIORITY(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .inst_req_i(instReq), .inst_wr_i(instWr), .inst_size_i(instSize),
        .inst_addr_i(instAddr), .inst_wdata_i(instWdata),
        .inst_rdata_o(instRdata1), .inst_addr_ok_o(instAddrOk1), .inst_data_ok_o(instDataOk1),
        .data_req_i(dataReq), .data_wr_i(dataWr), .data_size_i(dataSize),
        .data_addr_i(dataAddr), .data_wdata_i(dataWdata),
        .data_rdata_o(dataRdata1), .data_addr_ok_o(dataAddrOk1), .data_data_ok_o(dataDataOk1),
        .bus_req_o(busReq1), .bus_wr_o(busWr1), .bus_size_o(busSize1),
        .bus_addr_o(busAddr1), .bus_wdata_o(busWdata1),
        .bus_rdata_i(busRdata), .bus_addr_ok_i(busAddrOk), .bus_data_ok_i(busDataOk)
    );

    sram_like_arbiter #(.DATA_PRIORITY(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .inst_req_i(instReq), .inst_wr_i(instWr), .inst_size_i(instSize),
        .inst_addr_i(instAddr), .inst_wdata_i(instWdata),
        .inst_rdata_o(instRdata0), .inst_addr_ok_o(instAddrOk0), .inst_data_ok_o(instDataOk0),
        .data_req_i(dataReq), .data_wr_i(dataWr), .data_size_i(dataSize),
        .data_addr_i(dataAddr), .data_wdata_i(dataWdata),
        .data_rdata_o(dataRdata0), .data_addr_ok_o(dataAddrOk0), .data_data_ok_o(dataDataOk0),
        .bus_req_o(busReq0), .bus_wr_o(busWr0), .bus_size_o(busSize0),
        .bus_addr_o(busAddr0), .bus_wdata_o(busWdata0),
        .bus_rdata_i(busRdata), .bus_addr_ok_i(busAddrOk), .bus_data_ok_i(busDataOk)
    );

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        busRdata = 32'h1234_5678;
        nextCycle();
        nextCycle();
        @(negedge clk);
        compared++;
        if (busReq1 !== 1'b0 || busReq0 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busreq: got %0b/%0b want 0/0", busReq1, busReq0);
        end
        compared++;
        if (oks1 !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_oks: got %b want 0000", oks1);
        end
        compared++;
        if (bus1 !== 67'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_bus_fields: got %h want 0", bus1);
        end
        compared++;
        if (instRdata1 !== 32'h1234_5678 || dataRdata1 !== 32'h1234_5678) begin
            mismatched++;
            $display("[TB] FAIL reset_rdata: got %h/%h want 12345678", instRdata1, dataRdata1);
        end
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        instReq = 1'b1; instWr = 1'b0; instSize = 2'd2; instAddr = 32'hBFC0_0000; instWdata = 32'd0;
        expQ.push_back({1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'd0});
        @(negedge clk);
        compared++;
        if (busReq1 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_busreq_n: got %0b want 0", busReq1);
        end
        nextCycle();
        busAddrOk = 1'b1;
        @(negedge clk);
        compared++;
        if (busReq1 !== 1'b1 || oks1 !== 4'b1000) begin
            mismatched++;
            $display("[TB] FAIL single_accept: got req=%0b oks=%b want req=1 oks=1000", busReq1, oks1);
        end
        exp = expQ.pop_front();
        compared++;
        if (bus1 !== {exp.wr, exp.size, exp.addr, exp.wdata}) begin
            mismatched++;
            $display("[TB] FAIL single_bus_fields: got %h want %h", bus1, {exp.wr, exp.size, exp.addr, exp.wdata});
        end
        nextCycle();
        instReq = 1'b0; busAddrOk = 1'b0;
        @(negedge clk);
        compared++;
        if (busReq1 !== 1'b0 || oks1 !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL single_wait: got req=%0b oks=%b want req=0 oks=0000", busReq1, oks1);
        end
        nextCycle();
        busDataOk = 1'b1; busRdata = 32'h2408_0001;
        @(negedge clk);
        compared++;
        if (oks1 !== 4'b0100 || instRdata1 !== 32'h2408_0001) begin
            mismatched++;
            $display("[TB] FAIL single_done: got oks=%b rdata=%h want oks=0100 rdata=24080001", oks1, instRdata1);
        end
        nextCycle();
        busDataOk = 1'b0;
        @(negedge clk);
        compared++;
        if (busReq1 !== 1'b0 || oks1 !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL single_idle: got req=%0b oks=%b want req=0 oks=0000", busReq1, oks1);
        end
        nextCycle();
    endtask

    task automatic test_priority();
        instReq = 1'b1; instWr = 1'b0; instSize = 2'd2; instAddr = 32'h0000_1000; instWdata = 32'd0;
        dataReq = 1'b1; dataWr = 1'b1; dataSize = 2'd2; dataAddr = 32'h0000_2000; dataWdata = 32'hDEAD_BEEF;
        expQ.push_back({1'b1, 1'b1, 2'd2, 32'h0000_2000, 32'hDEAD_BEEF});
        expQ.push_back({1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'd0});
        nextCycle();
        busAddrOk = 1'b1;
        @(negedge clk);
        exp = expQ.pop_front();
        compared++;
        if (busReq1 !== 1'b1 || oks1 !== 4'b0010) begin
            mismatched++;
            $display("[TB] FAIL prio_data_accept: got req=%0b oks=%b want req=1 oks=0010", busReq1, oks1);
        end
        compared++;
        if (bus1 !== {exp.wr, exp.size, exp.addr, exp.wdata}) begin
            mismatched++;
            $display("[TB] FAIL prio_data_fields: got %h want %h", bus1, {exp.wr, exp.size, exp.addr, exp.wdata});
        end
        nextCycle();
        dataReq = 1'b0; busAddrOk = 1'b0; busDataOk = 1'b1;
        @(negedge clk);
        compared++;
        if (oks1 !== 4'b0001) begin
            mismatched++;
            $display("[TB] FAIL prio_data_done: got oks=%b want 0001", oks1);
        end
        nextCycle();
        busDataOk = 1'b0;
        @(negedge clk);
        compared++;
        if (busReq1 !== 1'b0 || oks1 !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL prio_no_bypass: got req=%0b oks=%b want req=0 oks=0000", busReq1, oks1);
        end
        nextCycle();
        busAddrOk = 1'b1; busDataOk = 1'b1;
        @(negedge clk);
        exp = expQ.pop_front();
        compared++;
        if (busReq1 !== 1'b1 || oks1 !== 4'b1100) begin
            mismatched++;
            $display("[TB] FAIL prio_inst_accept: got req=%0b oks=%b want req=1 oks=1100", busReq1, oks1);
        end
        compared++;
        if (bus1 !== {exp.wr, exp.size, exp.addr, exp.wdata}) begin
            mismatched++;
            $display("[TB] FAIL prio_inst_fields: got %h want %h", bus1, {exp.wr, exp.size, exp.addr, exp.wdata});
        end
        nextCycle();
        instReq = 1'b0; busAddrOk = 1'b0; busDataOk = 1'b0;
        nextCycle();
    endtask

    task automatic test_addr_stall();
        dataReq = 1'b1; dataWr = 1'b0; dataSize = 2'd0; dataAddr = 32'h0000_0040; dataWdata = 32'd0;
        expQ.push_back({1'b1, 1'b0, 2'd0, 32'h0000_0040, 32'd0});
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            dataAddr = 32'h0000_0080; dataWdata = 32'h1111_1111;
            @(negedge clk);
            exp = expQ[0];
            compared++;
            if (busReq1 !== 1'b1 || oks1 !== 4'b0000 || bus1 !== {exp.wr, exp.size, exp.addr, exp.wdata}) begin
                mismatched++;
                $display("[TB] FAIL stall_hold_%0d: got req=%0b oks=%b bus=%h want req=1 oks=0000 bus=%h",
                         i, busReq1, oks1, bus1, {exp.wr, exp.size, exp.addr, exp.wdata});
            end
        end
        nextCycle();
        busAddrOk = 1'b1;
        @(negedge clk);
        exp = expQ.pop_front();
        compared++;
        if (oks1 !== 4'b0010 || bus1 !== {exp.wr, exp.size, exp.addr, exp.wdata}) begin
            mismatched++;
            $display("[TB] FAIL stall_accept: got oks=%b bus=%h want oks=0010 bus=%h",
                     oks1, bus1, {exp.wr, exp.size, exp.addr, exp.wdata});
        end
        nextCycle();
        dataReq = 1'b0; busAddrOk = 1'b0; busDataOk = 1'b1; busRdata = 32'hCAFE_F00D;
        @(negedge clk);
        compared++;
        if (oks1 !== 4'b0001 || dataRdata1 !== 32'hCAFE_F00D) begin
            mismatched++;
            $display("[TB] FAIL stall_done: got oks=%b rdata=%h want oks=0001 rdata=cafef00d", oks1, dataRdata1);
        end
        nextCycle();
        busDataOk = 1'b0;
        nextCycle();
    endtask

    task automatic test_combined();
        instReq = 1'b1; instWr = 1'b1; instSize = 2'd1; instAddr = 32'h0000_3000; instWdata = 32'h55AA_55AA;
        expQ.push_back({1'b0, 1'b1, 2'd1, 32'h0000_3000, 32'h55AA_55AA});
        nextCycle();
        busAddrOk = 1'b1; busDataOk = 1'b1;
        @(negedge clk);
        exp = expQ.pop_front();
        compared++;
        if (oks1 !== 4'b1100 || bus1 !== {exp.wr, exp.size, exp.addr, exp.wdata}) begin
            mismatched++;
            $display("[TB] FAIL combined_accept: got oks=%b bus=%h want oks=1100 bus=%h",
                     oks1, bus1, {exp.wr, exp.size, exp.addr, exp.wdata});
        end
        nextCycle();
        instReq = 1'b0;
        @(negedge clk);
        compared++;
        if (busReq1 !== 1'b0 || oks1 !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL combined_idle_next: got req=%0b oks=%b want req=0 oks=0000", busReq1, oks1);
        end
        nextCycle();
        busAddrOk = 1'b0; busDataOk = 1'b0;
        nextCycle();
    endtask

    task automatic test_reset_in_data();
        instReq = 1'b1; instWr = 1'b0; instSize = 2'd2; instAddr = 32'h0000_0500; instWdata = 32'd0;
        expQ.push_back({1'b0, 1'b0, 2'd2, 32'h0000_0500, 32'd0});
        nextCycle();
        busAddrOk = 1'b1;
        @(negedge clk);
        exp = expQ.pop_front();
        compared++;
        if (oks1 !== 4'b1000 || bus1 !== {exp.wr, exp.size, exp.addr, exp.wdata}) begin
            mismatched++;
            $display("[TB] FAIL rstdata_accept: got oks=%b bus=%h want oks=1000 bus=%h",
                     oks1, bus1, {exp.wr, exp.size, exp.addr, exp.wdata});
        end
        nextCycle();
        instReq = 1'b0; busAddrOk = 1'b0; rst = 1'b1;
        nextCycle();
        rst = 1'b0; busRdata = 32'h0BAD_F00D;
        @(negedge clk);
        compared++;
        if (busReq1 !== 1'b0 || oks1 !== 4'b0000 || bus1 !== 67'd0 || instRdata1 !== 32'h0BAD_F00D) begin
            mismatched++;
            $display("[TB] FAIL rstdata_cleared: got req=%0b oks=%b bus=%h rdata=%h want 0/0000/0/0badf00d",
                     busReq1, oks1, bus1, instRdata1);
        end
        nextCycle();
        busDataOk = 1'b1;
        @(negedge clk);
        compared++;
        if (busReq1 !== 1'b0 || oks1 !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL rstdata_stale_ok: got req=%0b oks=%b want req=0 oks=0000", busReq1, oks1);
        end
        nextCycle();
        busDataOk = 1'b0;
        @(negedge clk);
        compared++;
        if (busReq1 !== 1'b0 || oks1 !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL rstdata_idle: got req=%0b oks=%b want req=0 oks=0000", busReq1, oks1);
        end
        nextCycle();
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        instReq = 1'b1; instWr = 1'b0; instSize = 2'd2; instAddr = 32'h0000_0100; instWdata = 32'd0;
        dataReq = 1'b1; dataWr = 1'b1; dataSize = 2'd2; dataAddr = 32'h0000_0200; dataWdata = 32'hA5A5_A5A5;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) expQ.push_back({1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'd0});
            else            expQ.push_back({1'b1, 1'b1, 2'd2, 32'h0000_0200, 32'hA5A5_A5A5});
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            compared++;
            if (busReq0 !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL rr_idle_%0d: got req=%0b want 0", k, busReq0);
            end
            nextCycle();
            busAddrOk = 1'b1; busDataOk = 1'b1;
            @(negedge clk);
            exp = expQ.pop_front();
            compared++;
            if (busReq0 !== 1'b1 || oks0 !== (exp.owner ? 4'b0011 : 4'b1100)
                || bus0 !== {exp.wr, exp.size, exp.addr, exp.wdata}) begin
                mismatched++;
                $display("[TB] FAIL rr_grant_%0d: got req=%0b oks=%b bus=%h want req=1 oks=%b bus=%h",
                         k, busReq0, oks0, bus0, exp.owner ? 4'b0011 : 4'b1100,
                         {exp.wr, exp.size, exp.addr, exp.wdata});
            end
            nextCycle();
            busAddrOk = 1'b0; busDataOk = 1'b0;
        end
        instReq = 1'b0; dataReq = 1'b0;
        nextCycle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_addr_stall();
        test_combined();
        test_reset_in_data();
        test_round_robin();
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d left want 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
